perf_monitor: RTL and testbench
===============================

Name: perf_monitor

Overview:
- Multi-channel performance monitor for the CPU core. Generalises the single cycle/time counter into NUM_CHANNELS saturating event counters plus a scaled time counter.
- A start PC and a final PC bound the measurement window. The block supports clear and freeze controls.
- A registered readout mux feeds the VGA overlay and the 7-segment display logic.

Parameters:
- NUM_CHANNELS, 4, number of event counters; channel 0 is hard-wired to count clock cycles.
- COUNT_WIDTH, 32, width of each event counter.
- TIME_WIDTH, 13, width of the time counter.
- PC_WIDTH, 16, width of the program counter.
- START_PC, 16'h0000, PC value that opens the measurement window.
- FINAL_PC, 16'hFFFF, PC value that closes the measurement window.
- TICK_DIV, 500_000, clock cycles per time tick; 500_000 gives hundredths of a second at 50 MHz.

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- resetN  in  1  asynchronous active-low reset.
- pc  in  PC_WIDTH  current program counter.
- pc_valid  in  1  pc is valid in this cycle.
- event_in  in  NUM_CHANNELS  per-channel event strobes; bit 0 is ignored.
- clear  in  1  synchronous clear of counters and state.
- freeze  in  1  pauses counting while asserted.
- rd_sel  in  $clog2(NUM_CHANNELS+1)  readout select.
- rd_data  out  COUNT_WIDTH  registered readout value.
- running  out  1  state is RUN.
- finished  out  1  state is DONE.
- saturated  out  NUM_CHANNELS+1  sticky saturation flags; bit NUM_CHANNELS is the time counter.

Behaviour:
- Reset: resetN low asynchronously forces all of the following:
  - state = IDLE
  - all counters, tick divider and saturated = 0
  - rd_data = 0, running = 0, finished = 0
- States and transitions (all transitions on the CLK_50 rising edge):
  - IDLE -> RUN when pc_valid && pc == START_PC.
  - RUN -> DONE when pc_valid && pc == FINAL_PC.
  - DONE holds until clear or reset.
  - FINAL_PC is not checked in IDLE.
  - If START_PC == FINAL_PC, the first match enters RUN and the second match enters DONE.
- clear: has the highest synchronous priority. It forces state = IDLE, zeroes all counters, the divider and saturated, and overrides any simultaneous transition or count.
- Counting enable: cnt_en = (state == RUN) && !freeze && !clear.
  - The cycle that enters RUN is not counted.
  - The cycle in RUN in which FINAL_PC matches is counted.
- freeze does not block state transitions.
- Channel 0 increments every cnt_en cycle.
- Channel i (i >= 1) increments when cnt_en && event_in[i].
- Saturation:
  - A counter at all-ones holds its value and never wraps.
  - saturated[i] sets on the cycle an increment is attempted while at all-ones.
  - saturated stays sticky until clear or reset.
- Time counter:
  - The divider counts 0..TICK_DIV-1 on cnt_en cycles.
  - On a cnt_en cycle with divider == TICK_DIV-1, the divider wraps to 0 and the time counter increments, saturating at 2**TIME_WIDTH-1 with flag bit NUM_CHANNELS.
  - The divider freezes with cnt_en; it does not reset on freeze.
- Readout:
  - rd_data is registered one cycle after rd_sel, computed from the counter values of that cycle before update.
  - rd_sel < NUM_CHANNELS returns that channel.
  - rd_sel == NUM_CHANNELS returns the time counter zero-extended to COUNT_WIDTH.
  - Any higher rd_sel returns 0.
- running and finished are decoded registered state with no extra latency beyond the state register.
- Reset mid-run: the asynchronous clear takes effect immediately. No partial values persist, and counting restarts only after a new START_PC match.

Test Plan:
1. TICK_DIV=4. Release reset. pc=START_PC valid for 1 cycle, then 10 cycles with pc != FINAL_PC, then pc=FINAL_PC valid -> finished=1; ch0 = 11; time counter = 2; running goes 1 for 11 cycles then 0.
2. In RUN, drive event_in[1] high on 5 cycles, 3 of them with freeze=1 -> ch1 = 2; ch0 excludes the 3 frozen cycles; the divider resumes from its held value after unfreeze.
3. COUNT_WIDTH=4, event_in[2] high for 20 run cycles -> ch2 = 15; saturated[2] = 1 from the 16th attempted increment; clear -> ch2 = 0 and saturated = 0.
4. clear asserted in the same cycle as the pc=START_PC match in IDLE -> state stays IDLE; all counters stay 0.
5. rd_sel sweeps 0..NUM_CHANNELS+2 -> rd_data matches each counter one cycle later; the time counter reads zero-extended; out-of-range selects read 0.
6. resetN pulsed low mid-RUN for less than one clock period -> all outputs are 0 immediately; pc=FINAL_PC afterwards leaves finished=0.

Source files
------------

// File: rtl/perf_monitor.sv
// ---------------------------------------------------------------------------
// perf_monitor
//
// Multi-channel performance monitor for the CPU core. A measurement window
// opens when the core fetches START_PC and closes when it fetches FINAL_PC.
// While the window is open, and not frozen, the block keeps:
//   - channel 0: a saturating count of clock cycles
//   - channels 1..NUM_CHANNELS-1: saturating counts of their event strobes
//   - a scaled time counter that advances once every TICK_DIV counted cycles
// Every counter holds at all-ones rather than wrapping, and sets a sticky
// saturation flag when an increment is lost. A registered readout mux
// presents one value at a time to the VGA overlay and the 7-segment logic.
//
// Ports:
//   CLK_50     in   system clock (50 MHz)
//   resetN     in   asynchronous active-low reset
//   pc         in   current program counter
//   pc_valid   in   pc is valid in this cycle
//   event_in   in   per-channel event strobes (bit 0 is not used; channel 0
//                   counts cycles)
//   clear      in   synchronous clear of counters, divider, flags and state
//   freeze     in   pauses counting while high (state changes still happen)
//   rd_sel     in   readout select: channel index, NUM_CHANNELS = time,
//                   anything higher reads as zero
//   rd_data    out  registered readout value, one cycle after rd_sel
//   running    out  measurement window is open
//   finished   out  measurement window has closed
//   saturated  out  sticky saturation flags; top bit is the time counter
// ---------------------------------------------------------------------------
module perf_monitor #(
  parameter int                 NUM_CHANNELS = 4,
  parameter int                 COUNT_WIDTH  = 32,
  parameter int                 TIME_WIDTH   = 13,
  parameter int                 PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] START_PC    = '0,
  parameter logic [PC_WIDTH-1:0] FINAL_PC    = '1,
  parameter int                 TICK_DIV     = 500_000
) (
  input  logic                                 CLK_50,
  input  logic                                 resetN,
  input  logic [PC_WIDTH-1:0]                  pc,
  input  logic                                 pc_valid,
  input  logic [NUM_CHANNELS-1:0]              event_in,
  input  logic                                 clear,
  input  logic                                 freeze,
  input  logic [$clog2(NUM_CHANNELS+1)-1:0]    rd_sel,
  output logic [COUNT_WIDTH-1:0]               rd_data,
  output logic                                 running,
  output logic                                 finished,
  output logic [NUM_CHANNELS:0]                saturated
);

  localparam int SEL_W = $clog2(NUM_CHANNELS + 1);

  // A divide-by-one divider still needs a one-bit register to keep the
  // code uniform; it simply never leaves zero.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                   state_q, state_d;
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]                         div_q, div_d;
  logic [TIME_WIDTH-1:0]                    time_q, time_d;
  logic [NUM_CHANNELS:0]                    sat_q, sat_d;
  logic [COUNT_WIDTH-1:0]                   rd_data_q, rd_data_d;

  logic                                     cnt_en;
  logic [NUM_CHANNELS-1:0]                  inc_req;
  logic                                     tick;

  // Window state machine. clear beats every transition; FINAL_PC is only
  // looked at once the window is open, so START_PC == FINAL_PC needs two
  // separate matches to open and then close the window.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (pc_valid && (pc == START_PC)) state_d = RUN;
        RUN:     if (pc_valid && (pc == FINAL_PC)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counting uses the registered state, so the cycle that opens the window
  // is not counted while the cycle that closes it is.
  always_comb begin
    cnt_en  = (state_q == RUN) && !freeze && !clear;
    inc_req = event_in & {NUM_CHANNELS{cnt_en}};
    // Channel 0 counts cycles, so its strobe is replaced by the enable.
    inc_req[0] = cnt_en;
    tick    = cnt_en && (div_q == DIV_LAST);
  end

  // Event counters and their flags. A counter at all-ones keeps its value;
  // the attempted increment is recorded in the sticky flag instead.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear) begin
      cnt_d = '0;
      sat_d = '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (inc_req[i]) begin
          if (cnt_q[i] == {COUNT_WIDTH{1'b1}}) begin
            sat_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
          end
        end
      end
      if (tick && (time_q == {TIME_WIDTH{1'b1}})) begin
        sat_d[NUM_CHANNELS] = 1'b1;
      end
    end
  end

  // Tick divider and time counter. The divider only moves on counted
  // cycles, so a freeze pauses it mid-period instead of restarting it.
  always_comb begin
    div_d  = div_q;
    time_d = time_q;
    if (clear) begin
      div_d  = '0;
      time_d = '0;
    end else if (cnt_en) begin
      if (tick) begin
        div_d = '0;
        if (time_q != {TIME_WIDTH{1'b1}}) begin
          time_d = time_q + TIME_WIDTH'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Readout mux works from the values held before this cycle's update, so
  // rd_data always shows a settled snapshot one cycle after rd_sel.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = cnt_q[i];
      end
    end
    if (rd_sel == SEL_W'(NUM_CHANNELS)) begin
      rd_data_d = COUNT_WIDTH'(time_q);
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      time_q    <= '0;
      sat_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      time_q    <= time_d;
      sat_q     <= sat_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign running   = (state_q == RUN);
  assign finished  = (state_q == DONE);
  assign saturated = sat_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_perf_monitor
//
// Bench for perf_monitor with small counters (4 bits) so saturation is
// reachable, a divide-by-4 time base and distinct start/final PCs.
// ---------------------------------------------------------------------------
module tb_perf_monitor;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int TW  = 4;
  localparam int TD  = 4;
  localparam logic [15:0] S_PC = 16'h0010;
  localparam logic [15:0] F_PC = 16'h0020;

  logic        CLK_50 = 1'b0;
  logic        resetN;
  logic [15:0] pc;
  logic        pc_valid;
  logic [3:0]  event_in;
  logic        clear;
  logic        freeze;
  logic [2:0]  rd_sel;
  logic [3:0]  rd_data;
  logic        running;
  logic        finished;
  logic [4:0]  saturated;

  perf_monitor #(
    .NUM_CHANNELS (NCH),
    .COUNT_WIDTH  (CW),
    .TIME_WIDTH   (TW),
    .PC_WIDTH     (16),
    .START_PC     (S_PC),
    .FINAL_PC     (F_PC),
    .TICK_DIV     (TD)
  ) dut (
    .CLK_50    (CLK_50),
    .resetN    (resetN),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .event_in  (event_in),
    .clear     (clear),
    .freeze    (freeze),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .running   (running),
    .finished  (finished),
    .saturated (saturated)
  );

  // 50 MHz clock
  always #10 CLK_50 = ~CLK_50;

  int total = 0;
  int bad   = 0;

  // Reference model: whole-window totals, with saturation and the time
  // base derived arithmetically from them.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t m_phase;
  int      m_cycles;
  int      m_events [NCH];

  function automatic int clip(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  function automatic int model_value(input int sel);
    if (sel == 0)        return clip(m_cycles, CW);
    else if (sel < NCH)  return clip(m_events[sel], CW);
    else if (sel == NCH) return clip(m_cycles / TD, TW);
    else                 return 0;
  endfunction

  function automatic int model_sat();
    int s;
    s = 0;
    if (m_cycles > (1 << CW) - 1) s = s | 1;
    for (int i = 1; i < NCH; i++)
      if (m_events[i] > (1 << CW) - 1) s = s | (1 << i);
    if ((m_cycles / TD) > (1 << TW) - 1) s = s | (1 << NCH);
    return s;
  endfunction

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_cycles = 0;
    for (int i = 0; i < NCH; i++) m_events[i] = 0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, step the model, then compare all outputs
  // against the model #1 after the clock edge.
  task automatic applyStimulus(input logic [15:0] p, input logic v, input logic [3:0] ev,
                               input logic c, input logic f, input logic [2:0] s);
    int exp_rd;
    pc       = p;
    pc_valid = v;
    event_in = ev;
    clear    = c;
    freeze   = f;
    rd_sel   = s;
    exp_rd   = model_value(int'(s));
    if (c) begin
      model_reset();
    end else begin
      if (m_phase == M_RUN && !f) begin
        m_cycles++;
        for (int i = 1; i < NCH; i++) if (ev[i]) m_events[i]++;
      end
      if (v) begin
        if (m_phase == M_IDLE && p == S_PC)     m_phase = M_RUN;
        else if (m_phase == M_RUN && p == F_PC) m_phase = M_DONE;
      end
    end
    @(posedge CLK_50);
    #1;
    checkOutput("model_running",   int'(running),   int'(m_phase == M_RUN));
    checkOutput("model_finished",  int'(finished),  int'(m_phase == M_DONE));
    checkOutput("model_saturated", int'(saturated), model_sat());
    checkOutput("model_rd_data",   int'(rd_data),   exp_rd);
  endtask

  // Read a value without disturbing the counters (freeze held high).
  task automatic readCheck(input logic [2:0] s, input int expected, input string name);
    applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, s);
    checkOutput(name, int'(rd_data), expected);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        pv;
    logic [3:0]  ev;
    logic        clr;
    logic        frz;
    logic [2:0]  sel;
    logic        e_run;
    logic        e_fin;
    int          e_rd;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] p, input logic v, input logic [3:0] ev,
                              input logic c, input logic f, input logic [2:0] s,
                              input logic er, input logic ef, input int erd);
    vec_t r;
    r.pc = p; r.pv = v; r.ev = ev; r.clr = c; r.frz = f; r.sel = s;
    r.e_run = er; r.e_fin = ef; r.e_rd = erd;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[$];
    int   sweep_exp [7];
    logic [15:0] rp;
    int   r;

    sweep_exp = '{11, 0, 0, 0, 2, 0, 0};

    // Clear together with the START_PC match keeps the block idle, then a
    // full window: open, ten counted cycles, close on FINAL_PC (counted),
    // then a readout sweep over every select value.
    vecs.push_back(mk(S_PC,     1, 4'h0, 1, 0, 3'd0, 0, 0, 0));
    vecs.push_back(mk(16'h0005, 1, 4'h0, 0, 0, 3'd0, 0, 0, 0));
    vecs.push_back(mk(S_PC,     1, 4'h0, 0, 0, 3'd0, 1, 0, 0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(16'h0030, 1, 4'h0, 0, 0, 3'd0, 1, 0, k));
    vecs.push_back(mk(F_PC,     1, 4'h0, 0, 0, 3'd0, 0, 1, 10));
    for (int s = 0; s < 7; s++)
      vecs.push_back(mk(16'h0000, 0, 4'h0, 0, 0, 3'(s), 0, 1, sweep_exp[s]));

    // Reset state
    resetN = 1'b0; pc = '0; pc_valid = 0; event_in = '0;
    clear = 0; freeze = 0; rd_sel = '0;
    model_reset();
    #5;
    checkOutput("reset_running",   int'(running),   0);
    checkOutput("reset_finished",  int'(finished),  0);
    checkOutput("reset_rd_data",   int'(rd_data),   0);
    checkOutput("reset_saturated", int'(saturated), 0);
    @(posedge CLK_50);
    #1;
    resetN = 1'b1;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pc, vecs[i].pv, vecs[i].ev, vecs[i].clr, vecs[i].frz, vecs[i].sel);
      checkOutput($sformatf("vec%0d_running", i),  int'(running),  int'(vecs[i].e_run));
      checkOutput($sformatf("vec%0d_finished", i), int'(finished), int'(vecs[i].e_fin));
      checkOutput($sformatf("vec%0d_rd_data", i),  int'(rd_data),  vecs[i].e_rd);
    end

    $display("[TB] freeze sequence");
    applyStimulus(16'h0000, 0, 4'h0, 1, 0, 3'd0);
    applyStimulus(S_PC,     1, 4'h0, 0, 0, 3'd0);
    applyStimulus(16'h0040, 1, 4'h2, 0, 0, 3'd0);
    for (int k = 0; k < 3; k++) applyStimulus(16'h0040, 1, 4'h2, 0, 1, 3'd0);
    applyStimulus(16'h0040, 1, 4'h2, 0, 0, 3'd0);
    applyStimulus(16'h0040, 1, 4'h0, 0, 0, 3'd0);
    applyStimulus(16'h0040, 1, 4'h0, 0, 0, 3'd0);
    readCheck(3'd0, 4, "freeze_ch0");
    readCheck(3'd1, 2, "freeze_ch1");
    readCheck(3'd4, 1, "freeze_time_divider_held");

    $display("[TB] saturation sequence");
    applyStimulus(16'h0000, 0, 4'h0, 1, 0, 3'd0);
    applyStimulus(S_PC,     1, 4'h0, 0, 0, 3'd0);
    for (int k = 1; k <= 68; k++) begin
      applyStimulus(16'h0040, 1, 4'h4, 0, 0, 3'd2);
      if (k == 15) checkOutput("sat2_before_16th", int'(saturated[2]), 0);
      if (k == 16) checkOutput("sat2_at_16th",     int'(saturated[2]), 1);
      if (k == 63) checkOutput("sat_time_before",  int'(saturated[4]), 0);
      if (k == 64) checkOutput("sat_time_at",      int'(saturated[4]), 1);
    end
    readCheck(3'd2, 15, "sat_ch2_held");
    readCheck(3'd4, 15, "sat_time_held");
    applyStimulus(16'h0000, 0, 4'h0, 1, 0, 3'd2);
    checkOutput("clear_reads_preclear", int'(rd_data), 15);
    readCheck(3'd2, 0, "clear_ch2_zero");
    checkOutput("clear_saturated_zero", int'(saturated), 0);

    $display("[TB] reset pulse mid-run");
    applyStimulus(S_PC,     1, 4'h0, 0, 0, 3'd0);
    for (int k = 0; k < 3; k++) applyStimulus(16'h0040, 1, 4'hE, 0, 0, 3'd0);
    #5;
    resetN = 1'b0;
    model_reset();
    #1;
    checkOutput("pulse_running",   int'(running),   0);
    checkOutput("pulse_finished",  int'(finished),  0);
    checkOutput("pulse_rd_data",   int'(rd_data),   0);
    checkOutput("pulse_saturated", int'(saturated), 0);
    #3;
    resetN = 1'b1;
    applyStimulus(F_PC, 1, 4'h0, 0, 0, 3'd0);
    checkOutput("pulse_final_ignored", int'(finished), 0);
    readCheck(3'd0, 0, "pulse_ch0_zero");

    $display("[TB] randomized run against model");
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r < 2)       rp = S_PC;
      else if (r == 2) rp = F_PC;
      else             rp = 16'($urandom);
      applyStimulus(rp,
                    1'($urandom_range(0, 3) != 0),
                    4'($urandom),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
